// File: rtl/ring_osc_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency meter.
package ring_osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned SETTLE_CYCLES_DEF = 8;
    localparam int unsigned GATE_CYCLES_DEF   = 100;
    localparam int unsigned CNT_WIDTH_DEF     = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the free-running oscillator into the clk domain and flags its rising edges.
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_in,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two metastability stages, then one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= osc_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ring_osc_meter.sv
// Enables the ring oscillator, lets it settle, counts its edges over a fixed clk window.
module ring_osc_meter
    import ring_osc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
    parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 osc_in,
    output logic                 osc_en,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 valid,
    output logic                 overflow
);

    localparam int unsigned WIN_W = $clog2(max_u(SETTLE_CYCLES, GATE_CYCLES) + 1);
    localparam logic [WIN_W-1:0]     SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [WIN_W-1:0]     GATE_LAST   = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    state_e               state_q,  state_d;
    logic [WIN_W-1:0]     win_q,    win_d;
    logic [CNT_WIDTH-1:0] edges_q,  edges_d;
    logic                 sat_q,    sat_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic                 ovf_q,    ovf_d;
    logic                 osc_en_q, osc_en_d;
    logic                 busy_q,   busy_d;
    logic                 valid_q,  valid_d;
    logic                 rise;

    osc_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .rise   (rise)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        edges_d  = edges_q;
        sat_d    = sat_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                win_d = '0;
                if (start) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (win_q == SETTLE_LAST) begin
                    win_d   = '0;
                    edges_d = '0;
                    sat_d   = 1'b0;
                    state_d = ST_GATE;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            ST_GATE: begin
                // Saturating edge count; a rise at full scale marks the result as clipped.
                if (rise) begin
                    if (edges_q == CNT_MAX) sat_d   = 1'b1;
                    else                    edges_d = edges_q + CNT_WIDTH'(1);
                end
                if (win_q == GATE_LAST) begin
                    win_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they line up with the state they describe;
        // the result takes edges_d so a rise on the final GATE cycle is included.
        osc_en_d = (state_d == ST_SETTLE) || (state_d == ST_GATE);
        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            count_d = edges_d;
            ovf_d   = sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            edges_q  <= '0;
            sat_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            osc_en_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            edges_q  <= edges_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            osc_en_q <= osc_en_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign count_o  = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Bench for ring_osc_meter: a 16-bit and a 4-bit meter share clk, start and the oscillator.
`timescale 1ns/1ps
module tb_ring_osc_meter;

    localparam int unsigned SETTLE = 8;
    localparam int unsigned GATE   = 100;
    localparam int          CLK_NS = 10;
    localparam int          WIN_NS = GATE * CLK_NS;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        osc_in;
    logic        osc_en,   osc_en_s;
    logic        busy,     busy_s;
    logic        valid,    valid_s;
    logic        overflow, overflow_s;
    logic [15:0] count_o;
    logic [3:0]  count_s;

    int n_checks = 0;
    int n_fail   = 0;

    bit osc_run  = 1'b0;
    int osc_half = 20;

    ring_osc_meter #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .osc_in(osc_in),
        .osc_en(osc_en), .busy(busy), .count_o(count_o), .valid(valid), .overflow(overflow)
    );

    ring_osc_meter #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_WIDTH(4)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .osc_in(osc_in),
        .osc_en(osc_en_s), .busy(busy_s), .count_o(count_s), .valid(valid_s), .overflow(overflow_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator model: free-running square wave, or stuck low when stopped.
    initial begin
        osc_in = 1'b0;
        forever begin
            if (osc_run) begin
                #(osc_half) osc_in = ~osc_in;
            end else begin
                osc_in = 1'b0;
                #1;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_osc(input int period_ns);
        if (period_ns == 0) begin
            osc_run = 1'b0;
        end else begin
            osc_half = period_ns / 2;
            osc_run  = 1'b1;
        end
        repeat (30) @(negedge clk);
    endtask

    // Reference: a window of WIN_NS holds floor or ceil(WIN/P) edges; allow one more edge of sync slop.
    function automatic void exp_range(input int period_ns, output int lo, output int hi);
        int q;
        if (period_ns == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            q  = WIN_NS / period_ns;
            lo = (q > 0) ? q - 1 : 0;
            hi = ((WIN_NS % period_ns) != 0 ? q + 1 : q) + 1;
        end
    endfunction

    // Issues one start pulse and observes 160 cycles; cycle c is the c-th cycle after the start edge.
    task automatic run_meas(input int period_ns, input int hold_lo, input int hold_hi,
                            output int lat, output int en_cyc, output int busy_cyc,
                            output int nvalid, output int hold_bad,
                            output logic [15:0] cnt, output logic ovf,
                            output logic [3:0] cnt_s, output logic ovf_s);
        lat = -1; en_cyc = 0; busy_cyc = 0; nvalid = 0; hold_bad = 0;
        cnt = '0; ovf = 1'b0; cnt_s = '0; ovf_s = 1'b0;
        set_osc(period_ns);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            if (c > 1) @(negedge clk);
            if (osc_en) en_cyc++;
            if (busy) busy_cyc++;
            if (valid) begin
                nvalid++;
                if (lat < 0) begin
                    lat   = c;
                    cnt   = count_o;
                    ovf   = overflow;
                    cnt_s = count_s;
                    ovf_s = overflow_s;
                end
            end else if (lat < 0) begin
                if (int'(count_o) < hold_lo || int'(count_o) > hold_hi) hold_bad++;
            end
        end
    endtask

    task automatic check_small(input string nm, input int lo, input int hi,
                               input logic [3:0] cs, input logic os);
        n_checks++;
        if (lo >= 16) begin
            if (cs !== 4'd15 || os !== 1'b1) begin
                n_fail++;
                $display("FAIL %s small: count=%0d ovf=%0b, required 15/1", nm, cs, os);
            end
        end else if (hi <= 15) begin
            if (int'(cs) < lo || int'(cs) > hi || os !== 1'b0) begin
                n_fail++;
                $display("FAIL %s small: count=%0d ovf=%0b, required %0d..%0d/0", nm, cs, os, lo, hi);
            end
        end else begin
            if ((os === 1'b1 && cs !== 4'd15) || int'(cs) < lo || os === 1'bx) begin
                n_fail++;
                $display("FAIL %s small: count=%0d ovf=%0b, required >=%0d, 15 if ovf", nm, cs, os, lo);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        n_checks++;
        if ({osc_en, busy, valid, overflow} !== 4'b0 || count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_main: en/busy/valid/ovf=%b count=%0d, required 0000/0",
                     {osc_en, busy, valid, overflow}, count_o);
        end
        n_checks++;
        if ({osc_en_s, busy_s, valid_s, overflow_s} !== 4'b0 || count_s !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_small: en/busy/valid/ovf=%b count=%0d, required 0000/0",
                     {osc_en_s, busy_s, valid_s, overflow_s}, count_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal;
        int lat, en, bz, nv, hb, lo, hi;
        logic [15:0] c; logic o; logic [3:0] cs; logic os;
        run_meas(40, 0, 65535, lat, en, bz, nv, hb, c, o, cs, os);
        n_checks++;
        if (lat !== 109 || nv !== 1) begin
            n_fail++;
            $display("FAIL nominal_latency: valid at %0d (%0d pulses), required 109 (1)", lat, nv);
        end
        n_checks++;
        if (en !== 108 || bz !== 109) begin
            n_fail++;
            $display("FAIL nominal_en_busy: osc_en=%0d busy=%0d cycles, required 108/109", en, bz);
        end
        n_checks++;
        if (c < 16'd24 || c > 16'd26 || o !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_count: count=%0d ovf=%0b, required 24..26/0", c, o);
        end
        exp_range(40, lo, hi);
        check_small("nominal", lo, hi, cs, os);
    endtask

    task automatic test_saturation;
        int lat, en, bz, nv, hb, lo, hi;
        logic [15:0] c; logic o; logic [3:0] cs; logic os;
        run_meas(30, 0, 65535, lat, en, bz, nv, hb, c, o, cs, os);
        n_checks++;
        if (cs !== 4'd15 || os !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: count=%0d ovf=%0b, required 15/1", cs, os);
        end
        exp_range(30, lo, hi);
        n_checks++;
        if (int'(c) < lo || int'(c) > hi || o !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_main: count=%0d ovf=%0b, required %0d..%0d/0", c, o, lo, hi);
        end
    endtask

    task automatic test_overwrite;
        int lat, en, bz, nv, hb, lo, hi;
        logic [15:0] c; logic o; logic [3:0] cs; logic os;
        run_meas(40, 0, 65535, lat, en, bz, nv, hb, c, o, cs, os);
        n_checks++;
        if (c < 16'd24 || c > 16'd26) begin
            n_fail++;
            $display("FAIL overwrite_first: count=%0d, required 24..26", c);
        end
        run_meas(80, 24, 26, lat, en, bz, nv, hb, c, o, cs, os);
        n_checks++;
        if (hb !== 0) begin
            n_fail++;
            $display("FAIL overwrite_hold: %0d cycles with count_o outside 24..26 before valid, required 0", hb);
        end
        exp_range(80, lo, hi);
        n_checks++;
        if (int'(c) < lo || int'(c) > hi || o !== 1'b0 || lat !== 109) begin
            n_fail++;
            $display("FAIL overwrite_second: count=%0d ovf=%0b lat=%0d, required %0d..%0d/0/109",
                     c, o, lat, lo, hi);
        end
    endtask

    task automatic test_reset_mid;
        int nv = 0;
        set_osc(40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (osc_en !== 1'b0 || busy !== 1'b0 || count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: osc_en=%b busy=%b count=%0d, required 0/0/0", osc_en, busy, count_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (valid || busy) nv++;
        end
        n_checks++;
        if (nv !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_novalid: %0d valid/busy cycles after abort, required 0", nv);
        end
    endtask

    task automatic test_dead;
        int lat, en, bz, nv, hb;
        logic [15:0] c; logic o; logic [3:0] cs; logic os;
        run_meas(0, 0, 65535, lat, en, bz, nv, hb, c, o, cs, os);
        n_checks++;
        if (c !== 16'd0 || o !== 1'b0 || lat !== 109 || nv !== 1) begin
            n_fail++;
            $display("FAIL dead_osc: count=%0d ovf=%0b lat=%0d pulses=%0d, required 0/0/109/1", c, o, lat, nv);
        end
        n_checks++;
        if (cs !== 4'd0 || os !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_osc_small: count=%0d ovf=%0b, required 0/0", cs, os);
        end
    endtask

    task automatic test_start_busy;
        int nv = 0;
        int lat = -1;
        set_osc(40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 250; c++) begin
            if (c > 1) @(negedge clk);
            if (valid) begin
                nv++;
                if (lat < 0) lat = c;
            end
            start = (c == 5 || c == 50) ? 1'b1 : 1'b0;
        end
        n_checks++;
        if (nv !== 1 || lat !== 109) begin
            n_fail++;
            $display("FAIL start_while_busy: %0d valid pulses first at %0d, required 1 at 109", nv, lat);
        end
    endtask

    task automatic test_back_to_back;
        int v[$];
        start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (valid) v.push_back(c);
        end
        start = 1'b0;
        repeat (120) @(negedge clk);
        n_checks++;
        if (v.size() < 3) begin
            n_fail++;
            $display("FAIL held_start_count: %0d valid pulses in 400 cycles, required >=3", v.size());
        end else if (v[1] - v[0] !== 110 || v[2] - v[1] !== 110) begin
            n_fail++;
            $display("FAIL held_start_spacing: spacing %0d,%0d, required 110,110", v[1] - v[0], v[2] - v[1]);
        end
    endtask

    task automatic test_random;
        int lat, en, bz, nv, hb, lo, hi, p;
        logic [15:0] c; logic o; logic [3:0] cs; logic os;
        for (int i = 0; i < 6; i++) begin
            p = 2 * int'($urandom_range(20, 200));
            exp_range(p, lo, hi);
            run_meas(p, 0, 65535, lat, en, bz, nv, hb, c, o, cs, os);
            n_checks++;
            if (int'(c) < lo || int'(c) > hi || o !== 1'b0 || lat !== 109 || en !== 108) begin
                n_fail++;
                $display("FAIL random_p%0d: count=%0d ovf=%0b lat=%0d en=%0d, required %0d..%0d/0/109/108",
                         p, c, o, lat, en, lo, hi);
            end
            check_small("random", lo, hi, cs, os);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_overwrite();
        test_reset_mid();
        test_dead();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Measurement block for the ring-oscillator clock: it enables the oscillator, waits for it to settle, counts its rising edges over a fixed window of system-clock cycles, and reports the count. It is the consuming end of the oscillator's `en`/`clk_out` pair. It drives `osc_en` into the oscillator's `en` and takes the oscillator's `clk_out` on `osc_in`. Its result is the frequency estimate used by lab software and benches.

## Interface
- `SETTLE_CYCLES`, default 8: clk cycles between enabling the oscillator and opening the count window; must be ≥1.
- `GATE_CYCLES`, default 100: length of the count window in clk cycles; must be ≥1.
- `CNT_WIDTH`, default 16: width of the edge count.

- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `osc_in` in 1: oscillator output, asynchronous to `clk`.
- `osc_en` out 1: enable to the oscillator.
- `busy` out 1: measurement in progress.
- `count_o` out CNT_WIDTH: last completed edge count, held until the next measurement completes.
- `valid` out 1: one-cycle pulse when `count_o` updates.
- `overflow` out 1: last measurement saturated; updates together with `count_o`.

## Operation
- **Input conditioning.** `osc_in` passes through a 2-FF synchronizer, then one further register. The rising-edge pulse is `rise = s2 & ~s3`.
- **FSM states:** IDLE, SETTLE, GATE, DONE.
  - **IDLE:** `osc_en`=0, `busy`=0. If `start`=1, go to SETTLE.
  - **SETTLE:** `osc_en`=1, `busy`=1. The window counter counts to SETTLE_CYCLES and then the FSM goes to GATE. The edge counter clears on entry to GATE.
  - **GATE:** `osc_en`=1, `busy`=1. Each cycle with `rise`=1 increments the edge counter. The counter saturates at 2^CNT_WIDTH−1, and a sticky saturation flag is set on any `rise` while the counter is already at that maximum. After exactly GATE_CYCLES cycles the FSM goes to DONE.
  - **DONE:** one cycle. `osc_en`=0, `busy`=1. On entry, the edge count is latched into `count_o` and the saturation flag into `overflow`, and `valid`=1. The next state is IDLE.
- **`start` behaviour.** `start` is ignored outside IDLE. If `start` is held high, a new measurement begins on the cycle after the FSM returns to IDLE.
- **Dead oscillator.** A stopped oscillator yields `count_o`=0 with `valid`=1. There is no timeout or error state.
- **Accuracy.** Results are accurate to ±1 edge for f_osc ≤ f_clk/4. Above f_clk/2 the count is undefined, with no detection.

## Timing
- **Reset values.** While `rst_n`=0: `osc_en`, `busy`, `valid` and `overflow` are 0, `count_o` is 0, the synchronizer flops are 0, and the state is IDLE. Reset takes effect immediately, with no clock edge needed.
- **Reset mid-measurement.** Asserting reset during a measurement aborts it. `osc_en` drops asynchronously and no `valid` is produced.
- **Start latency.** `start` high at edge k puts SETTLE in cycle k+1, with `osc_en`=1 from that cycle.
- **Window position.**
  - GATE occupies cycles k+1+SETTLE_CYCLES through k+SETTLE_CYCLES+GATE_CYCLES.
  - DONE, with `valid`=1, is cycle k+1+SETTLE_CYCLES+GATE_CYCLES.
  - IDLE resumes one cycle later.
- **Total cost.** A measurement occupies SETTLE_CYCLES+GATE_CYCLES+1 cycles of `busy`.
- **Edge-counting latency.** `osc_in` edge → `rise` takes 2–3 clk cycles. Only `rise` pulses that fall inside GATE cycles are counted; this fixed latency cancels out over the window.
- **Saturation and edge case.** In a saturated window the final count equals exactly 2^CNT_WIDTH−1. A `rise` on the last GATE cycle is counted.

## Structure
- **Package `ring_osc_pkg`** holds:
  - the state enum (IDLE, SETTLE, GATE, DONE);
  - the default constants for SETTLE_CYCLES, GATE_CYCLES and CNT_WIDTH.
- **Counter width.** The window counter width is $clog2(max(SETTLE_CYCLES, GATE_CYCLES)+1).
- **Sub-module `osc_edge_sync`:** the 3-flop synchronizer with the rise detector; asynchronous reset to 0; output `rise`.

## Test plan
- **Nominal count.** clk 10 ns, GATE=100, SETTLE=8, `osc_in` period 40 ns, one `start` pulse → `valid` once, 109 cycles after the `start` edge; `count_o` ∈ {24, 25, 26}; `overflow`=0; `osc_en` high for exactly 108 cycles.
- **Saturation.** CNT_WIDTH=4, `osc_in` period 30 ns, GATE=100 → `count_o`=15, `overflow`=1.
- **Dead oscillator.** `osc_in` held at 0 → `count_o`=0, `overflow`=0, `valid` pulses on schedule.
- **Reset mid-GATE.** `rst_n` low 50 cycles after `start` → `osc_en`, `busy`, `count_o` go to 0 immediately; no `valid` until a new `start`.
- **Start while busy, then held.** A `start` pulse in SETTLE or GATE → ignored, one `valid` only. `start` held high → `valid` pulses exactly 110 cycles apart.
- **Result hold and overwrite.** Two measurements at osc periods 40 ns then 80 ns → `count_o` holds ≈25 until the second `valid`, then becomes ≈12–13.
